// File: rtl/alu_sequencer.sv
// alu_sequencer: issue-side controller for the 16-bit ALU.
// Accepts one request at a time, drives the ALU operand/opcode lines,
// pulses start and waits on the matching done line for div/mod/mul,
// captures result/flags and hands them back over a valid/ready response port.
module alu_sequencer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,

    output logic [4:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic        alu_start,
    input  logic [15:0] alu_result,
    input  logic [15:0] alu_result_high,
    input  logic        alu_done_div,
    input  logic        alu_done_mod,
    input  logic        alu_done_mul,
    input  logic        alu_z,
    input  logic        alu_n,
    input  logic        alu_c,
    input  logic        alu_v,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [15:0] rsp_result_high,
    output logic [3:0]  rsp_flags,
    output logic        rsp_err,
    output logic        busy
);

    // Counter must be able to hold TIMEOUT_CYCLES; keep at least one bit so a
    // disabled timeout still elaborates cleanly.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    localparam logic [4:0] OP_DIV = 5'd2;
    localparam logic [4:0] OP_MOD = 5'd5;
    localparam logic [4:0] OP_MUL = 5'd7;
    localparam logic [4:0] OP_MAX = 5'd17;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_START,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state;
    logic [4:0]       op_q;
    logic [15:0]      a_q;
    logic [15:0]      b_q;
    logic [CNT_W-1:0] wait_cnt;
    logic             done_match;
    logic             timeout_hit;

    // Operands reach the ALU straight from the latches, so they stay put
    // from one acceptance to the next.
    assign alu_op = op_q;
    assign alu_a  = a_q;
    assign alu_b  = b_q;

    // Select the single done line that belongs to the latched opcode.
    always_comb begin
        // NOTE: default first so every path assigns done_match and no latch is inferred.
        done_match = 1'b0;
        case (op_q)
            OP_DIV:  done_match = alu_done_div;
            OP_MOD:  done_match = alu_done_mod;
            OP_MUL:  done_match = alu_done_mul;
            default: done_match = 1'b0;
        endcase
    end

    // Limit reached on this WAIT cycle; a zero TIMEOUT_CYCLES never fires.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_LAST);

    // Sequencer FSM: state, operand latches, WAIT counter and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: only non-blocking assignments here, so every flop samples pre-edge values.
        if (!rst) begin
            // NOTE: operand latches are reset too because they drive the ALU pins directly.
            state           <= S_IDLE;
            op_q            <= '0;
            a_q             <= '0;
            b_q             <= '0;
            wait_cnt        <= '0;
            req_ready       <= 1'b1;
            busy            <= 1'b0;
            alu_start       <= 1'b0;
            rsp_valid       <= 1'b0;
            rsp_result      <= '0;
            rsp_result_high <= '0;
            rsp_flags       <= '0;
            rsp_err         <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q      <= req_op;
                        a_q       <= req_a;
                        b_q       <= req_b;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (req_op > OP_MAX) begin
                            // Illegal opcode: answer immediately, never touch the ALU.
                            rsp_result      <= '0;
                            rsp_result_high <= '0;
                            rsp_flags       <= '0;
                            rsp_err         <= 1'b1;
                            rsp_valid       <= 1'b1;
                            state           <= S_RESP;
                        end else if (req_op == OP_DIV || req_op == OP_MOD ||
                                     req_op == OP_MUL) begin
                            alu_start <= 1'b1;
                            state     <= S_START;
                        end else begin
                            state <= S_EXEC;
                        end
                    end
                end

                S_EXEC: begin
                    // Combinational unit: ALU outputs settled during this cycle.
                    rsp_result      <= alu_result;
                    rsp_result_high <= alu_result_high;
                    rsp_flags       <= {alu_z, alu_n, alu_c, alu_v};
                    rsp_err         <= 1'b0;
                    rsp_valid       <= 1'b1;
                    state           <= S_RESP;
                end

                S_START: begin
                    // Start is high for exactly this one cycle; done lines ignored here.
                    alu_start <= 1'b0;
                    wait_cnt  <= '0;
                    state     <= S_WAIT;
                end

                S_WAIT: begin
                    // A done on the limit cycle wins over the timeout.
                    if (done_match) begin
                        rsp_result      <= alu_result;
                        rsp_result_high <= alu_result_high;
                        rsp_flags       <= {alu_z, alu_n, alu_c, alu_v};
                        rsp_err         <= 1'b0;
                        rsp_valid       <= 1'b1;
                        state           <= S_RESP;
                    end else if (timeout_hit) begin
                        rsp_result      <= '0;
                        rsp_result_high <= '0;
                        rsp_flags       <= '0;
                        rsp_err         <= 1'b1;
                        rsp_valid       <= 1'b1;
                        state           <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                S_RESP: begin
                    // Response fields hold until the consumer takes them.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    // Unused encodings fall back to a clean idle.
                    alu_start <= 1'b0;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer. A behavioural ALU stub answers the
// DUT's opcode/operand lines; the expected response of every transaction is
// derived from the sequencing rules (latency per op class, error cases,
// captured values) rather than from the DUT's internals.
module tb_alu_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus
    logic        req_valid, req_valid_to, rsp_ready;
    logic [4:0]  req_op;
    logic [15:0] req_a, req_b;
    logic        alu_done_div, alu_done_mod, alu_done_mul;
    logic [15:0] alu_result, alu_result_high;
    logic        alu_z, alu_n, alu_c, alu_v;
    logic        use_to;

    // Main DUT (default timeout)
    logic        req_ready, alu_start, rsp_valid, rsp_err, busy;
    logic [4:0]  alu_op;
    logic [15:0] alu_a, alu_b, rsp_result, rsp_result_high;
    logic [3:0]  rsp_flags;

    // Short-timeout DUT
    logic        to_req_ready, to_alu_start, to_rsp_valid, to_rsp_err, to_busy;
    logic [4:0]  to_alu_op;
    logic [15:0] to_alu_a, to_alu_b, to_rsp_result, to_rsp_result_high;
    logic [3:0]  to_rsp_flags;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] last_res, last_high;
    logic [3:0]  last_flags;
    logic        last_err;

    alu_sequencer dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_start(alu_start),
        .alu_result(alu_result), .alu_result_high(alu_result_high),
        .alu_done_div(alu_done_div), .alu_done_mod(alu_done_mod), .alu_done_mul(alu_done_mul),
        .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_result_high(rsp_result_high), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .busy(busy)
    );

    alu_sequencer #(.TIMEOUT_CYCLES(8)) dut_to (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_to), .req_ready(to_req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .alu_op(to_alu_op), .alu_a(to_alu_a), .alu_b(to_alu_b), .alu_start(to_alu_start),
        .alu_result(alu_result), .alu_result_high(alu_result_high),
        .alu_done_div(alu_done_div), .alu_done_mod(alu_done_mod), .alu_done_mul(alu_done_mul),
        .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v),
        .rsp_valid(to_rsp_valid), .rsp_ready(rsp_ready), .rsp_result(to_rsp_result),
        .rsp_result_high(to_rsp_result_high), .rsp_flags(to_rsp_flags), .rsp_err(to_rsp_err),
        .busy(to_busy)
    );

    // ---------------- ALU stub / reference arithmetic ----------------
    typedef struct packed {
        logic [15:0] res;
        logic [15:0] high;
        logic [3:0]  flags;   // {Z,N,C,V}
    } alu_out_t;

    function automatic bit is_multi(input logic [4:0] op);
        return (op == 5'd2) || (op == 5'd5) || (op == 5'd7);
    endfunction

    function automatic alu_out_t stub_alu(input logic [4:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
        alu_out_t    o;
        logic [16:0] s;
        logic [31:0] w;
        o = '0;
        s = '0;
        w = '0;
        case (op)
            5'd10: begin
                s = {1'b0, a} + {1'b0, b};
                o.res = s[15:0];
                o.flags[1] = s[16];
                o.flags[0] = (a[15] == b[15]) && (s[15] != a[15]);
            end
            5'd3: begin
                s = {1'b0, a} + 17'd1;
                o.res = s[15:0];
                o.flags[1] = s[16];
                o.flags[0] = (a == 16'h7FFF);
            end
            5'd2: begin
                if (b != 16'd0) begin o.res = a / b; o.high = a % b; end
                else begin o.res = 16'hFFFF; o.high = a; end
            end
            5'd5: o.res = (b != 16'd0) ? (a % b) : a;
            5'd7: begin
                w = {16'd0, a} * {16'd0, b};
                o.res  = w[15:0];
                o.high = w[31:16];
            end
            5'd15, 5'd17: begin
                o.res = 16'd0;
                o.flags[1] = (a < b);
            end
            default: begin
                o.res  = a ^ b ^ {11'd0, op};
                o.high = a & b;
                o.flags[1] = a[0];
                o.flags[0] = b[15];
            end
        endcase
        if (op == 5'd15 || op == 5'd17) begin
            o.flags[3] = (a == b);
            o.flags[2] = ($signed(a) < $signed(b));
        end else begin
            o.flags[3] = (o.res == 16'd0);
            o.flags[2] = o.res[15];
        end
        return o;
    endfunction

    logic [4:0]  s_op;
    logic [15:0] s_a, s_b;
    alu_out_t    s_out;
    assign s_op = use_to ? to_alu_op : alu_op;
    assign s_a  = use_to ? to_alu_a  : alu_a;
    assign s_b  = use_to ? to_alu_b  : alu_b;

    // Multi-cycle results are only meaningful while a done line is high.
    always_comb begin
        s_out = stub_alu(s_op, s_a, s_b);
        if (is_multi(s_op) && !(alu_done_div || alu_done_mod || alu_done_mul)) begin
            s_out.res   = 16'hBAD0;
            s_out.high  = 16'hBAD1;
            s_out.flags = 4'b1010;
        end
    end
    assign alu_result      = s_out.res;
    assign alu_result_high = s_out.high;
    assign {alu_z, alu_n, alu_c, alu_v} = s_out.flags;

    task automatic clear_done();
        alu_done_div = 1'b0;
        alu_done_mod = 1'b0;
        alu_done_mul = 1'b0;
    endtask

    // Raise the done line for op, or one of the two unrelated lines when stray.
    task automatic raise_done(input logic [4:0] op, input bit stray);
        case (op)
            5'd2:    if (stray) alu_done_mul = 1'b1; else alu_done_div = 1'b1;
            5'd5:    if (stray) alu_done_div = 1'b1; else alu_done_mod = 1'b1;
            default: if (stray) alu_done_mod = 1'b1; else alu_done_mul = 1'b1;
        endcase
    endtask

    task automatic wait_idle(input string tag);
        int c;
        c = 0;
        while (req_ready !== 1'b1 && c < 100) begin @(negedge clk); c++; end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s idle_wait: req_ready=%b required 1", tag, req_ready);
        end
    endtask

    // One full transaction on the main DUT, checked against the sequencing rules.
    task automatic run_op(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                          input int lat, input int rdy_delay, input string tag);
        alu_out_t exp;
        logic     exp_err;
        int       exp_lat, c, starts, start_at, unstable, seen, hold_bad;
        bit       multi;
        multi   = is_multi(op);
        exp_err = (op > 5'd17);
        exp     = exp_err ? alu_out_t'('0) : stub_alu(op, a, b);
        exp_lat = exp_err ? 1 : (multi ? lat + 2 : 2);

        wait_idle(tag);
        use_to    = 1'b0;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        rsp_ready = (rdy_delay == 0);
        starts = 0; start_at = 0; unstable = 0; seen = 0; c = 0;
        while (seen == 0 && c < 200) begin
            @(negedge clk);
            c++;
            if (alu_start === 1'b1) begin
                starts++;
                if (start_at == 0) start_at = c;
            end
            if (alu_op !== op || alu_a !== a || alu_b !== b) unstable++;
            if (rsp_valid === 1'b1) seen = c;
            if (c == 1) begin
                n_checks++;
                if (busy !== 1'b1 || req_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s busy_after_accept: busy=%b req_ready=%b required 1/0",
                             tag, busy, req_ready);
                end
                req_valid = 1'b0;
                req_a = 16'($urandom);
                req_b = 16'($urandom);
                req_op = 5'($urandom);
            end
            clear_done();
            if (multi && seen == 0) begin
                if (c == 1) raise_done(op, 1'b0);           // must be ignored in START
                if (c == 2 && lat > 2) raise_done(op, 1'b1); // unrelated line in WAIT
                if (c == 1 + lat) raise_done(op, 1'b0);
            end
        end
        clear_done();

        n_checks++;
        if (seen != exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: op=%0d got %0d cycles required %0d", tag, op, seen, exp_lat);
        end
        n_checks++;
        if (starts != (multi ? 1 : 0) || (multi && start_at != 1)) begin
            n_fail++;
            $display("FAIL %s start_pulse: op=%0d pulses=%0d at=%0d required %0d at 1",
                     tag, op, starts, start_at, multi ? 1 : 0);
        end
        n_checks++;
        if (unstable != 0) begin
            n_fail++;
            $display("FAIL %s operand_stability: %0d unstable cycles required 0", tag, unstable);
        end
        n_checks++;
        if ({rsp_result, rsp_result_high, rsp_flags, rsp_err} !== {exp.res, exp.high, exp.flags, exp_err}) begin
            n_fail++;
            $display("FAIL %s response: op=%0d got res=%h high=%h flags=%b err=%b required res=%h high=%h flags=%b err=%b",
                     tag, op, rsp_result, rsp_result_high, rsp_flags, rsp_err,
                     exp.res, exp.high, exp.flags, exp_err);
        end
        last_res   = rsp_result;
        last_high  = rsp_result_high;
        last_flags = rsp_flags;
        last_err   = rsp_err;

        hold_bad = 0;
        for (int d = 0; d < rdy_delay; d++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_result !== last_res || rsp_result_high !== last_high ||
                rsp_flags !== last_flags || rsp_err !== last_err || alu_a !== a || alu_b !== b)
                hold_bad++;
        end
        if (rdy_delay > 0) begin
            n_checks++;
            if (hold_bad != 0) begin
                n_fail++;
                $display("FAIL %s response_hold: %0d unstable cycles required 0", tag, hold_bad);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after_handshake: valid=%b ready=%b busy=%b required 0/1/0",
                     tag, rsp_valid, req_ready, busy);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_req_ready: got %b required 1", req_ready);
        end
        n_checks++;
        if ({busy, alu_start, rsp_valid, rsp_err} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_controls: busy/start/valid/err=%b required 0000",
                               {busy, alu_start, rsp_valid, rsp_err});
        end
        n_checks++;
        if ({alu_op, alu_a, alu_b, rsp_result, rsp_result_high, rsp_flags} !== '0) begin
            n_fail++; $display("FAIL reset_data: op=%h a=%h b=%h res=%h high=%h flags=%h required 0",
                               alu_op, alu_a, alu_b, rsp_result, rsp_result_high, rsp_flags);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        run_op(5'd10, 16'h7FFF, 16'h0001, 0, 0, "add");
        n_checks++;
        if ({last_res, last_flags, last_err} !== {16'h8000, 4'b0101, 1'b0}) begin
            n_fail++; $display("FAIL add_values: res=%h flags=%b err=%b required 8000/0101/0",
                               last_res, last_flags, last_err);
        end
    endtask

    task automatic test_mul();
        run_op(5'd7, 16'h0100, 16'h0100, 17, 0, "mul");
        n_checks++;
        if ({last_res, last_high} !== {16'h0000, 16'h0001}) begin
            n_fail++; $display("FAIL mul_values: res=%h high=%h required 0000/0001", last_res, last_high);
        end
    endtask

    task automatic test_illegal();
        run_op(5'd20, 16'($urandom), 16'($urandom), 0, 0, "illegal");
        n_checks++;
        if ({last_err, last_res, last_high, last_flags} !== {1'b1, 36'd0}) begin
            n_fail++; $display("FAIL illegal_values: err=%b res=%h high=%h flags=%b required 1/0/0/0",
                               last_err, last_res, last_high, last_flags);
        end
    endtask

    task automatic test_timeout(input bit with_done);
        logic [15:0] a, b;
        alu_out_t    e;
        int          c, first, start_bad;
        string       tag;
        tag = with_done ? "timeout_done" : "timeout";
        a = 16'($urandom);
        b = 16'($urandom_range(1, 255));
        use_to = 1'b1;
        rsp_ready = 1'b1;
        req_op = 5'd2; req_a = a; req_b = b; req_valid_to = 1'b1;
        first = 0; c = 0; start_bad = 0;
        while (first == 0 && c < 40) begin
            @(negedge clk);
            c++;
            if (c == 1) begin
                req_valid_to = 1'b0;
                if (to_alu_start !== 1'b1) start_bad++;
            end else if (to_alu_start !== 1'b0) start_bad++;
            if (to_rsp_valid === 1'b1) first = c;
            clear_done();
            if (first == 0) begin
                if (c == 3 || c == 5) alu_done_mul = 1'b1;
                if (c == 6) alu_done_mod = 1'b1;
                if (with_done && c == 9) alu_done_div = 1'b1;
            end
        end
        clear_done();
        n_checks++;
        if (first != 10) begin
            n_fail++; $display("FAIL %s wait_length: response at cycle %0d required 10", tag, first);
        end
        n_checks++;
        if (start_bad != 0) begin
            n_fail++; $display("FAIL %s start_pulse: %0d bad cycles required 0", tag, start_bad);
        end
        e = with_done ? stub_alu(5'd2, a, b) : alu_out_t'('0);
        n_checks++;
        if ({to_rsp_result, to_rsp_result_high, to_rsp_flags, to_rsp_err} !==
            {e.res, e.high, e.flags, ~with_done}) begin
            n_fail++;
            $display("FAIL %s response: res=%h high=%h flags=%b err=%b required %h/%h/%b/%b", tag,
                     to_rsp_result, to_rsp_result_high, to_rsp_flags, to_rsp_err,
                     e.res, e.high, e.flags, ~with_done);
        end
        @(negedge clk);
        n_checks++;
        if (to_busy !== 1'b0 || to_rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL %s release: busy=%b valid=%b required 0/0", tag, to_busy, to_rsp_valid);
        end
        use_to = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [15:0] a1, b1, a2, b2;
        alu_out_t    e1, e2;
        int          bad;
        a1 = 16'($urandom); b1 = 16'($urandom);
        a2 = 16'($urandom); b2 = 16'($urandom);
        e1 = stub_alu(5'd10, a1, b1);
        e2 = stub_alu(5'd4, a2, b2);
        wait_idle("backpressure");
        rsp_ready = 1'b0;
        req_op = 5'd10; req_a = a1; req_b = b1; req_valid = 1'b1;
        @(negedge clk);
        req_op = 5'd4; req_a = a2; req_b = b2;
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, rsp_result, rsp_result_high, rsp_flags} !== {1'b1, e1.res, e1.high, e1.flags}) begin
            n_fail++; $display("FAIL bp_first_rsp: valid=%b res=%h high=%h flags=%b required 1/%h/%h/%b",
                               rsp_valid, rsp_result, rsp_result_high, rsp_flags, e1.res, e1.high, e1.flags);
        end
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || alu_a !== a1 ||
                {rsp_result, rsp_result_high, rsp_flags} !== {e1.res, e1.high, e1.flags})
                bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL bp_hold: %0d unstable cycles required 0", bad);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || alu_a !== a1) begin
            n_fail++; $display("FAIL bp_handshake: ready=%b valid=%b alu_a=%h required 1/0/%h",
                               req_ready, rsp_valid, alu_a, a1);
        end
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b0 || alu_op !== 5'd4 || alu_a !== a2 || alu_b !== b2 || rsp_result !== e1.res) begin
            n_fail++; $display("FAIL bp_second_accept: ready=%b op=%0d a=%h res=%h required 0/4/%h/%h",
                               req_ready, alu_op, alu_a, rsp_result, a2, e1.res);
        end
        req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, rsp_result, rsp_result_high, rsp_flags, rsp_err} !==
            {1'b1, e2.res, e2.high, e2.flags, 1'b0}) begin
            n_fail++; $display("FAIL bp_second_rsp: valid=%b res=%h high=%h flags=%b err=%b required 1/%h/%h/%b/0",
                               rsp_valid, rsp_result, rsp_result_high, rsp_flags, rsp_err,
                               e2.res, e2.high, e2.flags);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        wait_idle("mid_wait");
        rsp_ready = 1'b1;
        req_op = 5'd2; req_a = 16'($urandom); req_b = 16'($urandom); req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL mid_wait_busy: got %b required 1", busy);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, busy, alu_start, rsp_valid, rsp_err} !== 5'b10000) begin
            n_fail++; $display("FAIL mid_wait_reset_ctrl: ready/busy/start/valid/err=%b required 10000",
                               {req_ready, busy, alu_start, rsp_valid, rsp_err});
        end
        n_checks++;
        if ({alu_op, alu_a, alu_b, rsp_result, rsp_result_high, rsp_flags} !== '0) begin
            n_fail++; $display("FAIL mid_wait_reset_data: op=%h a=%h b=%h res=%h required 0",
                               alu_op, alu_a, alu_b, rsp_result);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_op(5'd3, 16'hFFFF, 16'($urandom), 0, 0, "inc_after_reset");
        n_checks++;
        if (last_res !== 16'h0000 || last_flags[3] !== 1'b1 || last_err !== 1'b0) begin
            n_fail++; $display("FAIL inc_values: res=%h Z=%b err=%b required 0000/1/0",
                               last_res, last_flags[3], last_err);
        end
    endtask

    task automatic test_back_to_back(input bit illegal);
        int         acc[$];
        int         cyc;
        bit         rdy_prev;
        logic [4:0] op;
        string      tag;
        tag = illegal ? "b2b_illegal" : "b2b_comb";
        wait_idle(tag);
        rsp_ready = 1'b1;
        if (illegal) op = 5'($urandom_range(18, 31));
        else do op = 5'($urandom_range(0, 17)); while (is_multi(op));
        req_op = op; req_a = 16'($urandom); req_b = 16'($urandom); req_valid = 1'b1;
        rdy_prev = req_ready;
        cyc = 0;
        while (acc.size() < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (rdy_prev) begin
                acc.push_back(cyc);
                if (illegal) op = 5'($urandom_range(18, 31));
                else do op = 5'($urandom_range(0, 17)); while (is_multi(op));
                req_op = op; req_a = 16'($urandom); req_b = 16'($urandom);
            end
            rdy_prev = req_ready;
        end
        req_valid = 1'b0;
        n_checks++;
        if (acc.size() != 4) begin
            n_fail++; $display("FAIL %s accept_count: got %0d required 4", tag, acc.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                n_checks++;
                if (acc[i] - acc[i-1] != (illegal ? 2 : 3)) begin
                    n_fail++; $display("FAIL %s issue_interval: got %0d required %0d",
                                       tag, acc[i] - acc[i-1], illegal ? 2 : 3);
                end
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_random();
        logic [4:0] op;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) begin
                case ($urandom_range(0, 2))
                    0: op = 5'd2;
                    1: op = 5'd5;
                    default: op = 5'd7;
                endcase
            end else begin
                op = 5'($urandom_range(0, 23));
            end
            run_op(op, 16'($urandom), 16'($urandom), int'($urandom_range(1, 20)),
                   int'($urandom_range(0, 2)), "random");
        end
    endtask

    initial begin
        req_valid = 1'b0; req_valid_to = 1'b0; rsp_ready = 1'b0;
        req_op = '0; req_a = '0; req_b = '0; use_to = 1'b0;
        clear_done();
        test_reset();
        test_add();
        test_mul();
        test_illegal();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_backpressure();
        test_reset_mid_wait();
        test_back_to_back(1'b0);
        test_back_to_back(1'b1);
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Issue-side controller for the 16-bit ALU. It accepts one operation request at a time over a valid/ready handshake and drives the ALU's op/operand/start inputs. For the multi-cycle units (div, mod, mul) it waits for the matching done line. It then captures result, result_high and the Z/N/C/V flags, and returns them over a valid/ready response port. It sits between the instruction decode/execute control and the ALU.

## Interface
- TIMEOUT_CYCLES, 64: maximum WAIT cycles before a multi-cycle op is abandoned; 0 disables the timeout.
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request (high only in IDLE)
- req_op  input  5  ALU opcode (0..17 legal)
- req_a, req_b  input  16  operands
- alu_op  output  5  opcode to ALU
- alu_a, alu_b  output  16  operands to ALU
- alu_start  output  1  one-cycle start pulse for div/mod/mul
- alu_result, alu_result_high  input  16  ALU results
- alu_done_div, alu_done_mod, alu_done_mul  input  1  multi-cycle completion lines
- alu_z, alu_n, alu_c, alu_v  input  1  ALU flags
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_result, rsp_result_high  output  16  captured results
- rsp_flags  output  4  captured {Z,N,C,V}
- rsp_err  output  1  illegal opcode or timeout
- busy  output  1  high whenever state is not IDLE

## Operation
- States: IDLE, EXEC, START, WAIT, RESP. Encoding is free.
- IDLE: req_ready=1. On req_valid, latch req_op/a/b into operand registers.
  - op > 17 → RESP with err=1.
  - op in {2, 5, 7} → START.
  - Otherwise → EXEC.
- alu_op/alu_a/alu_b are driven continuously from the operand registers. They stay stable from acceptance until the next acceptance.
- EXEC: capture alu_result, alu_result_high, flags → RESP.
- START: alu_start=1 for exactly this cycle → WAIT. Done lines are ignored in START.
- WAIT:
  - Only the done line matching the latched op is observed: 2→done_div, 5→done_mod, 7→done_mul. The other two are ignored.
  - On the matching done, capture results and flags → RESP with err=0.
  - A cycle counter runs in WAIT. If TIMEOUT_CYCLES≠0 and TIMEOUT_CYCLES WAIT cycles elapse without done → RESP with err=1, result/result_high/flags=0.
- RESP: rsp_valid=1. All rsp_* are held stable until rsp_ready=1; that cycle → IDLE. rsp_valid deasserts the next cycle.
- Illegal op: rsp_result/result_high/flags=0, alu_start never asserted.
- Ops 15 (test) and 17 (cmp): result is whatever the ALU presents (0). Flags are captured normally.
- rsp_* registers change only on capture; the next request does not clear them.

## Timing
- Reset (rst low, async) forces:
  - State = IDLE.
  - req_ready=1.
  - Zero on alu_op, alu_a, alu_b, alu_start, rsp_valid, rsp_result, rsp_result_high, rsp_flags, rsp_err, busy.
  - Timeout counter cleared.
- Acceptance at edge k:
  - Combinational op: rsp_valid high in cycle k+2, i.e. 2 cycles after acceptance.
  - Illegal op: rsp_valid high at k+1.
  - Multi-cycle op: alu_start high in cycle k+1; WAIT from k+2. A done sampled high at edge d gives rsp_valid from d onward.
- Minimum issue interval, with rsp_ready held high:
  - Combinational: 3 cycles.
  - Illegal: 2 cycles.
- No request is accepted while busy. req_valid held across busy cycles is accepted on the first IDLE cycle.
- A matching done in the same cycle as the timeout limit takes priority: err=0, results captured.
- Reset during WAIT/START: alu_start drops immediately and the pending op is discarded. ALU reset is handled separately.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1.

## Test plan
- ADD: op=10, A=0x7FFF, B=0x0001, bench ALU model → rsp_valid exactly 2 cycles after acceptance, rsp_result=0x8000, rsp_flags={0,1,0,1}, rsp_err=0, alu_start never high.
- MUL: op=7, A=0x0100, B=0x0100; stub raises alu_done_mul 17 cycles after start with high=0x0001, low=0x0000:
  - exactly one alu_start pulse;
  - alu_a/alu_b stable throughout;
  - rsp_result=0x0000, rsp_result_high=0x0001.
- Illegal op 5'd20 → rsp_valid at k+1, rsp_err=1, result/flags 0, alu_start never asserted.
- Timeout (TIMEOUT_CYCLES=8): op=2, done_div never asserted, stray done_mul pulses in WAIT → rsp_err=1 after exactly 8 WAIT cycles, results 0. Repeat with done_div on the 8th WAIT cycle → err=0.
- Backpressure: rsp_ready low for 5 cycles with req_valid high → rsp_* stable, req_ready=0, second request accepted only on the cycle after the response handshake.
- Reset mid-WAIT on a div → all outputs zero without a clock edge. After release, op=3 (inc) A=0xFFFF completes normally with result 0x0000, Z=1.
